// File: rtl/rle_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rle_capture_fifo
// Purpose  : Run-length compressor for capture samples feeding a FWFT FIFO
//            of {run_len, data} entries with count/flag outputs.
// Revision : 1.0 - initial release
// ============================================================================
module rle_capture_fifo #(
    parameter int DATA_W            = 16,
    parameter int CNT_W             = 16,
    parameter int ADDR_W            = 9,
    parameter int PROG_EMPTY_THRESH = 4
) (
    input  logic                     core_clk,
    input  logic                     core_rst,
    input  logic                     capture_valid,
    input  logic [DATA_W-1:0]        capture_data,
    input  logic                     flush,
    input  logic                     rd_en,
    output logic [CNT_W+DATA_W-1:0]  dout,
    output logic                     full,
    output logic                     empty,
    output logic                     prog_empty,
    output logic [ADDR_W:0]          count,
    output logic                     overflow
);

    localparam int ENTRY_W = CNT_W + DATA_W;
    localparam int DEPTH   = 1 << ADDR_W;

    logic                run_active_q, run_active_d;
    logic [DATA_W-1:0]   run_data_q,   run_data_d;
    logic [CNT_W-1:0]    run_cnt_q,    run_cnt_d;

    logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [ADDR_W:0]     count_q,      count_d;
    logic                full_q,       full_d;
    logic                empty_q,      empty_d;
    logic                prog_empty_q, prog_empty_d;
    logic                overflow_q,   overflow_d;
    logic [ENTRY_W-1:0]  dout_q,       dout_d;

    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                emit;
    logic [ENTRY_W-1:0]  emit_entry;
    logic                do_wr;
    logic                do_rd;
    logic [ADDR_W-1:0]   rd_next_ptr;

    // Run tracker: a flush always closes the run and a same-cycle sample
    // starts a fresh one, even when its value matches the closed run.
    always_comb begin
        run_active_d = run_active_q;
        run_data_d   = run_data_q;
        run_cnt_d    = run_cnt_q;
        emit         = 1'b0;
        emit_entry   = {run_cnt_q, run_data_q};
        if (flush) begin
            emit         = run_active_q;
            run_active_d = capture_valid;
            if (capture_valid) begin
                run_data_d = capture_data;
                run_cnt_d  = '0;
            end
        end else if (capture_valid) begin
            if (!run_active_q) begin
                run_active_d = 1'b1;
                run_data_d   = capture_data;
                run_cnt_d    = '0;
            end else if ((capture_data == run_data_q) && (run_cnt_q != '1)) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end else begin
                emit       = 1'b1;
                run_data_d = capture_data;
                run_cnt_d  = '0;
            end
        end
    end

    // FIFO bookkeeping; full is judged before any same-cycle read frees space.
    always_comb begin
        do_wr        = emit && !full_q;
        do_rd        = rd_en && !empty_q;
        rd_next_ptr  = rd_ptr_q + 1'b1;
        wr_ptr_d     = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = do_rd ? rd_next_ptr : rd_ptr_q;
        count_d      = count_q + (ADDR_W+1)'(do_wr) - (ADDR_W+1)'(do_rd);
        full_d       = (count_d == (ADDR_W+1)'(DEPTH));
        empty_d      = (count_d == '0);
        prog_empty_d = (count_d <= (ADDR_W+1)'(PROG_EMPTY_THRESH));
        overflow_d   = overflow_q || (emit && full_q);
        dout_d       = dout_q;
        // The written entry becomes head only when nothing else remains.
        if (do_wr && (empty_q || (do_rd && (count_q == (ADDR_W+1)'(1))))) begin
            dout_d = emit_entry;
        end else if (do_rd && (count_q > (ADDR_W+1)'(1))) begin
            dout_d = mem_q[rd_next_ptr];
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst) begin
            run_active_q <= 1'b0;
            run_data_q   <= '0;
            run_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            dout_q       <= '0;
        end else begin
            run_active_q <= run_active_d;
            run_data_q   <= run_data_d;
            run_cnt_q    <= run_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            prog_empty_q <= prog_empty_d;
            overflow_q   <= overflow_d;
            dout_q       <= dout_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst && do_wr) begin
            mem_q[wr_ptr_q] <= emit_entry;
        end
    end

    assign dout       = dout_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign prog_empty = prog_empty_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rle_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_capture_fifo
// Purpose  : Directed bench for rle_capture_fifo with hand-computed entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rle_capture_fifo;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b0;
    logic        capture_valid = 1'b0;
    logic [15:0] capture_data = '0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] dout;
    logic        full, empty, prog_empty, overflow;
    logic [9:0]  count;

    int vectors = 0;
    int miscompares = 0;

    rle_capture_fifo dut (
        .core_clk      (core_clk),
        .core_rst      (core_rst),
        .capture_valid (capture_valid),
        .capture_data  (capture_data),
        .flush         (flush),
        .rd_en         (rd_en),
        .dout          (dout),
        .full          (full),
        .empty         (empty),
        .prog_empty    (prog_empty),
        .count         (count),
        .overflow      (overflow)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic f, input logic r);
        capture_valid = v;
        capture_data  = d;
        flush         = f;
        rd_en         = r;
        @(posedge core_clk);
        #1;
        capture_valid = 1'b0;
        flush         = 1'b0;
        rd_en         = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        chk({tag, "_notempty"}, 32'(empty), 32'd0);
        chk({tag, "_dout"}, dout, exp);
        step(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic flags(input string tag, input int cnt, input logic f, input logic ov);
        chk({tag, "_count"}, 32'(count), 32'(cnt));
        chk({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, "_full"}, 32'(full), 32'(f));
        chk({tag, "_prog_empty"}, 32'(prog_empty), 32'(cnt <= 4));
        chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
    endtask

    initial begin
        // Reset with random inputs
        core_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            capture_valid = 1'($urandom);
            capture_data  = 16'($urandom);
            flush         = 1'($urandom);
            rd_en         = 1'($urandom);
            @(posedge core_clk);
            #1;
        end
        flags("rst", 0, 1'b0, 1'b0);
        chk("rst_dout", dout, 32'h0);
        capture_valid = 1'b0; flush = 1'b0; rd_en = 1'b0;
        core_rst = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        flags("rst_idle", 0, 1'b0, 1'b0);

        // Run then change
        for (int i = 0; i < 5; i++) step(1'b1, 16'h00AA, 1'b0, 1'b0);
        flags("run_open", 0, 1'b0, 1'b0);
        step(1'b1, 16'h0055, 1'b0, 1'b0);
        flags("run_first", 1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        flags("run_flush", 2, 1'b0, 1'b0);
        pop("run0", 32'h000400AA);
        pop("run1", 32'h00000055);
        flags("run_drained", 0, 1'b0, 1'b0);

        // Every-cycle toggle
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, (k % 2 == 1) ? 16'h1234 : 16'hFFFF, 1'b0, 1'b0);
            flags($sformatf("tog_k%0d", k), k - 1, 1'b0, 1'b0);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0);
        flags("tog_flush", 10, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            pop($sformatf("tog_e%0d", i), (i % 2 == 0) ? 32'h00001234 : 32'h0000FFFF);
        flags("tog_drained", 0, 1'b0, 1'b0);

        // Saturation: 65537 equal samples
        for (int i = 0; i < 65537; i++) step(1'b1, 16'h0F0F, 1'b0, 1'b0);
        flags("sat_split", 1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        pop("sat0", 32'hFFFF0F0F);
        pop("sat1", 32'h00000F0F);

        // Flush concurrent with an equal sample
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        flags("fsc", 2, 1'b0, 1'b0);
        pop("fsc0", 32'h00020001);
        pop("fsc1", 32'h00000001);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        flags("fsc_idle_flush", 0, 1'b0, 1'b0);

        // Simultaneous read/write: on empty, then on non-empty
        step(1'b1, 16'h0A0A, 1'b0, 1'b0);
        step(1'b1, 16'h0B0B, 1'b0, 1'b1);
        flags("rw_empty", 1, 1'b0, 1'b0);
        chk("rw_empty_dout", dout, 32'h00000A0A);
        step(1'b1, 16'h0C0C, 1'b0, 1'b1);
        flags("rw_mid", 1, 1'b0, 1'b0);
        chk("rw_mid_dout", dout, 32'h00000B0B);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        flags("rw_flush", 1, 1'b0, 1'b0);
        pop("rw_last", 32'h00000C0C);

        // Full / overflow: 513 distinct samples then flush
        for (int i = 0; i < 513; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        flags("fill", 512, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        flags("ovf", 512, 1'b1, 1'b1);
        for (int i = 0; i < 512; i++) pop($sformatf("drain%0d", i), {16'h0, 16'(i)});
        flags("drained", 0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        flags("rd_on_empty", 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rle_capture_fifo.md
Name: rle_capture_fifo

Overview:
- Run-length compressor for the 16-channel logic-analyzer capture path, followed by a synchronous entry FIFO.
- Each accepted sample either extends the current run or closes it.
- A closed run is written to the FIFO as one 32-bit entry {run_len, data}.
- Sits between the capture front end and the SDRAM write logic, all in the core clock domain.

Parameters:
- DATA_W, 16, sample width.
- CNT_W, 16, run-length field width.
- ADDR_W, 9, FIFO address width; depth = 2**ADDR_W = 512 entries.
- PROG_EMPTY_THRESH, 4, prog_empty asserted when count <= this value.

Ports:
- core_clk  in  1  sole clock, rising edge.
- core_rst  in  1  reset; one clock; reset is synchronous and active-low.
- capture_valid  in  1  capture_data is a valid sample this cycle.
- capture_data  in  16  sample value.
- flush  in  1  single-cycle pulse; closes the current run.
- rd_en  in  1  pop head entry.
- dout  out  32  head entry: [31:16] run_len, [15:0] data.
- full  out  1  FIFO holds 512 entries.
- empty  out  1  FIFO holds 0 entries.
- prog_empty  out  1  count <= PROG_EMPTY_THRESH.
- count  out  10  entries stored, 0..512.
- overflow  out  1  sticky; set when an entry is dropped because the FIFO is full.

Behaviour:
- Reset (core_rst low at a clock edge):
  - Run state cleared (run_active=0, run_data=0, run_cnt=0).
  - FIFO pointers cleared; count=0, empty=1, full=0, prog_empty=1, overflow=0, dout=0.
  - Inputs are ignored while reset is low.
- run_len encoding: number of samples in the run minus 1. 0 = one sample, 0xFFFF = 65536 samples.
- Per edge with capture_valid=1 and flush=0:
  - run_active=0: start run; run_data=capture_data, run_cnt=0, run_active=1.
  - capture_data==run_data and run_cnt!=0xFFFF: run_cnt+1.
  - Otherwise (value change or saturation): emit {run_cnt, run_data}; restart run with capture_data, run_cnt=0.
- flush=1:
  - If run_active, emit {run_cnt, run_data}.
  - Then, if capture_valid=1, start a new run with capture_data, run_cnt=0, even when it equals the old data. Otherwise run_active=0.
  - flush with run_active=0 and capture_valid=0 emits nothing.
- capture_valid=0 and flush=0: run state holds.
- At most one emission per cycle.
- Emission = FIFO write on the same edge that processes the closing sample or flush. Cycle after the edge: count incremented and empty=0.
- Emission while full=1 (evaluated before any same-cycle read): entry dropped, overflow set to 1 until reset. A dropped entry is not retried.
- FIFO read is first-word-fall-through:
  - dout shows the head entry whenever empty=0.
  - rd_en=1 with empty=0 advances the head at the edge.
  - rd_en while empty=1 is ignored and has no side effects.
- Simultaneous read and write, FIFO neither empty nor full: both happen, count unchanged.
- Simultaneous read and write, empty=1: write occurs, read ignored.
- Simultaneous read and write, full=1: write dropped (overflow set), read occurs.
- dout while empty=1: holds its last value; content is don't-care.
- Pointers wrap modulo 512.
- full, empty, prog_empty and count are registered and exact on the cycle after each edge; no early or lazy flags.

Test Plan:
- Reset: hold core_rst low 2 cycles with random inputs -> empty=1, full=0, prog_empty=1, count=0, overflow=0.
- Run then change: 5 samples 0x00AA, then 1 sample 0x0055, then flush -> entries 0x000400AA then 0x00000055. count=2; prog_empty stays 1.
- Every-cycle toggle: 0x1234/0xFFFF alternating for 10 cycles, then flush -> 10 entries, each with run_len=0 and correct data order. prog_empty drops once count=5.
- Saturation: 65537 samples of 0x0F0F, then flush -> entries 0xFFFF0F0F then 0x00000F0F.
- Flush with a same-cycle sample: run of 3×0x0001, then flush concurrent with capture 0x0001, then flush -> entries 0x00020001 then 0x00000001.
- Full/overflow: 513 distinct samples with no reads, then flush -> full=1, count=512, overflow=1. 512 reads return the first 512 runs in order; the 513th run is lost; empty=1 at the end.
